wb_mem_port_arbiter: RTL

//   Two-master Wishbone B4 classic arbiter. Shares one single-port memory/slave

---
 rtl/wb_mem_port_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/wb_mem_port_arbiter.sv
// wb_mem_port_arbiter
//   Two-master Wishbone B4 classic arbiter. It shares one single-port slave
//   between the CPU instruction bus (m0) and the CPU data bus (m1).
//   Contention is resolved round-robin. A grant lasts until the owning
//   master drops cyc, so block and burst cycles are never split.
//   A watchdog aborts a strobe that stays unanswered for TMO_CYC cycles.
//   The abort returns err to the master and pulses tmo_irq_o.
//
// Ports
//   clk, rst         system clock; synchronous active-high reset
//   m0_* / m1_*      Wishbone slave-side ports for the instr / data master
//   s_*              Wishbone master-side port toward the shared memory
//   gnt_o            one-hot registered grant (01 = m0, 10 = m1, 00 = none)
//   tmo_irq_o        one-cycle pulse on every watchdog abort
module wb_mem_port_arbiter #(
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TMO_CYC = 255
) (
   input  logic            clk,
   input  logic            rst,

   input  logic [AW-1:0]   m0_adr_i,
   input  logic [DW-1:0]   m0_dat_i,
   output logic [DW-1:0]   m0_dat_o,
   input  logic            m0_we_i,
   input  logic [DW/8-1:0] m0_sel_i,
   input  logic            m0_cyc_i,
   input  logic            m0_stb_i,
   output logic            m0_ack_o,
   output logic            m0_err_o,

   input  logic [AW-1:0]   m1_adr_i,
   input  logic [DW-1:0]   m1_dat_i,
   output logic [DW-1:0]   m1_dat_o,
   input  logic            m1_we_i,
   input  logic [DW/8-1:0] m1_sel_i,
   input  logic            m1_cyc_i,
   input  logic            m1_stb_i,
   output logic            m1_ack_o,
   output logic            m1_err_o,

   output logic [AW-1:0]   s_adr_o,
   output logic [DW-1:0]   s_dat_o,
   input  logic [DW-1:0]   s_dat_i,
   output logic            s_we_o,
   output logic [DW/8-1:0] s_sel_o,
   output logic            s_cyc_o,
   output logic            s_stb_o,
   input  logic            s_ack_i,
   input  logic            s_err_i,

   output logic [1:0]      gnt_o,
   output logic            tmo_irq_o
);

   typedef enum logic [1:0] {StIdle, StG0, StG1, StAbort} state_e;

   // Counter value seen in the TMO_CYC-th unanswered strobe cycle.
   localparam logic [15:0] TmoLast = 16'(TMO_CYC - 1);

   state_e      state_q;
   logic [1:0]  gnt_q;
   logic        last_gnt_q;   // 0 = m0 owned the bus last, 1 = m1
   logic [15:0] tmo_cnt_q;
   logic        tmo_irq_q;

   logic g0, g1;
   logic resp;
   logic tmo_hit;

   assign g0   = (state_q == StG0);
   assign g1   = (state_q == StG1);
   assign resp = s_ack_i | s_err_i;

   // Slave-side mux: everything is zero unless a master holds the grant.
   always_comb begin
      s_adr_o = '0;
      s_dat_o = '0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      if (g0) begin
         s_adr_o = m0_adr_i;
         s_dat_o = m0_dat_i;
         s_we_o  = m0_we_i;
         s_sel_o = m0_sel_i;
         s_cyc_o = m0_cyc_i;
         s_stb_o = m0_stb_i;
      end else if (g1) begin
         s_adr_o = m1_adr_i;
         s_dat_o = m1_dat_i;
         s_we_o  = m1_we_i;
         s_sel_o = m1_sel_i;
         s_cyc_o = m1_cyc_i;
         s_stb_o = m1_stb_i;
      end
   end

   // A response arriving in the last allowed cycle beats the watchdog.
   assign tmo_hit = (g0 | g1) & s_cyc_o & s_stb_o & ~resp & (tmo_cnt_q == TmoLast);

   assign m0_ack_o  = g0 & s_ack_i;
   assign m1_ack_o  = g1 & s_ack_i;
   assign m0_err_o  = g0 & (s_err_i | tmo_hit);
   assign m1_err_o  = g1 & (s_err_i | tmo_hit);
   assign m0_dat_o  = g0 ? s_dat_i : '0;
   assign m1_dat_o  = g1 ? s_dat_i : '0;
   assign gnt_o     = gnt_q;
   assign tmo_irq_o = tmo_irq_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         gnt_q      <= 2'b00;
         last_gnt_q <= 1'b1;
         tmo_cnt_q  <= '0;
         tmo_irq_q  <= 1'b0;
      end else begin
         tmo_irq_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               tmo_cnt_q <= '0;
               if (m0_cyc_i && (!m1_cyc_i || last_gnt_q)) begin
                  state_q <= StG0;
                  gnt_q   <= 2'b01;
               end else if (m1_cyc_i) begin
                  state_q <= StG1;
                  gnt_q   <= 2'b10;
               end
            end
            StG0, StG1: begin
               if (!s_cyc_o) begin
                  // Owner released the bus, possibly mid-transfer.
                  state_q    <= StIdle;
                  gnt_q      <= 2'b00;
                  last_gnt_q <= g1;
                  tmo_cnt_q  <= '0;
               end else if (resp) begin
                  tmo_cnt_q <= '0;
               end else if (tmo_hit) begin
                  state_q    <= StAbort;
                  gnt_q      <= 2'b00;
                  last_gnt_q <= g1;
                  tmo_cnt_q  <= '0;
                  tmo_irq_q  <= 1'b1;
               end else if (s_stb_o && (tmo_cnt_q != 16'hFFFF)) begin
                  tmo_cnt_q <= tmo_cnt_q + 16'd1;
               end
            end
            StAbort: begin
               state_q   <= StIdle;
               tmo_cnt_q <= '0;
            end
            default: begin
               state_q <= StIdle;
               gnt_q   <= 2'b00;
            end
         endcase
      end
   end

endmodule
